pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic, parametrised pipeline stage register with a valid/ready handshake. Each pipeline
//  boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) is built from instances of this block.
//  An optional skid entry registers o_ready, so backpressure does not form a combinational path.
//  Supports flush to a bubble and carries a saturating bubble-cycle performance counter.
// PARAMETERS
//  DATA_W    32  width of the payload carried across the stage (instruction, PC+4, control bits)
//  SKID_EN   1   1: two-entry stage with registered o_ready; 0: single register, combinational o_ready
//  NOP_DATA  0   payload value driven on o_data at reset and after flush (DATA_W bits)
//  CNT_W     16  width of the bubble counter
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  i_flush      in   1       discard all held and incoming payloads at the next edge
//  i_valid      in   1       upstream payload valid
//  o_ready      out  1       stage can accept a payload this cycle
//  i_data       in   DATA_W  upstream payload
//  o_valid      out  1       downstream payload valid
//  i_ready      in   1       downstream accepts a payload (0 = hold/stall)
//  o_data       out  DATA_W  downstream payload
//  o_bubble_cnt out  CNT_W   count of cycles in which o_valid=0, saturating
//  i_cnt_clr    in   1       synchronous clear of o_bubble_cnt
// BEHAVIOUR
//  Reset (async):
//   o_valid=0, skid empty, o_data=NOP_DATA, o_bubble_cnt=0.
//   o_ready=1 for SKID_EN=1; for SKID_EN=0, o_ready follows its combinational rule.
//  Transfers:
//   in_fire  = i_valid & o_ready
//   out_fire = o_valid & i_ready
//   Payload is never dropped or duplicated except by flush.
//  SKID_EN=1 state machine (pipe_pkg::stage_st_t):
//   EMPTY -> ONE on in_fire.
//   ONE stays ONE on in_fire & out_fire (main <= i_data).
//   ONE -> EMPTY on out_fire & !in_fire.
//   ONE -> FULL on in_fire & !out_fire (skid <= i_data).
//   FULL -> ONE on out_fire (main <= skid).
//   o_ready = (state != FULL), registered. Latency is 1 cycle EMPTY->o_valid; FIFO order is kept.
//  SKID_EN=0:
//   o_ready = !o_valid | i_ready.
//   in_fire loads main; out_fire & !in_fire clears o_valid.
//  Flush (highest priority after reset; wins over stall, unlike the legacy IF/ID hold-over-flush):
//   At the next edge all entries are invalid, state=EMPTY, o_data=NOP_DATA.
//   A same-cycle in_fire is discarded.
//   Upstream must re-present the payload after flush if it is still wanted.
//  Payload while o_valid=0: o_data keeps its last value, except after reset or flush (NOP_DATA).
//  Bubble counter:
//   Increments each edge where o_valid=0 and no flush/clear; saturates at 2^CNT_W-1.
//   i_cnt_clr sets it to 0 and takes priority over the increment.
//   Flush cycles are counted as bubbles from the following cycle.
//  Mid-operation reset: state, data and counter return to reset values immediately, with no edge needed.
//  Invariants (assertions):
//   o_valid stable and o_data unchanged while o_valid & !i_ready & !i_flush.
//   Skid valid implies main valid.
// STRUCTURE
//  pipe_pkg:
//   - stage_st_t enum {ST_EMPTY, ST_ONE, ST_FULL}, 2 bits
//   - localparam NOP_INSTR = 32'h0000_0000 used as the IF/ID NOP_DATA
//  Sub-module pipe_perf_counter (CNT_W, inc, clr, saturating).
//  Datapath and FSM stay in this module; SKID_EN is selected by a generate block.
// TESTING
//  1. Reset mid-FULL, reset asserted between edges -> o_valid=0, o_data=0, o_ready=1, cnt=0 immediately.
//  2. SKID_EN=1, i_ready=0, send 0xA, 0xB, 0xC back-to-back ->
//     0xA, 0xB accepted, o_ready=0 on cycle 3, 0xC held upstream.
//     Then i_ready=1 -> out 0xA, 0xB, 0xC in order, no loss.
//  3. Streaming, i_valid=i_ready=1 for 8 cycles with data 1..8 ->
//     o_data 1..8 one cycle late, o_ready constant 1, cnt unchanged.
//  4. FULL with 0x11/0x22, i_flush=1 together with i_valid (0x33) ->
//     next cycle o_valid=0, o_data=NOP_DATA, state EMPTY, 0x33 not output.
//  5. Flush with i_ready=0 (stall) -> flush still wins; o_valid=0 next edge.
//  6. CNT_W=4, idle 20 cycles -> cnt saturates at 15; i_cnt_clr=1 -> 0 next edge.
//     Repeat scenarios 2-4 with SKID_EN=0: no accepted payload is lost.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_st_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: saturating event counter with synchronous clear.
module pipe_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional skid entry,
// flush-to-bubble and a saturating bubble-cycle counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter bit                SKID_EN  = 1'b1,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INSTR),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    input  logic              i_cnt_clr
);
    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = i_valid & o_ready;
    assign w_out_fire = o_valid & i_ready;

    generate
        if (SKID_EN) begin : g_skid
            stage_st_t         r_state, w_state_nxt;
            logic [DATA_W-1:0] r_main, r_skid, w_main_nxt, w_skid_nxt;
            logic              r_ready;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= ST_EMPTY;
                    r_main  <= NOP_DATA;
                    r_skid  <= NOP_DATA;
                    r_ready <= 1'b1;
                end else begin
                    r_state <= w_state_nxt;
                    r_main  <= w_main_nxt;
                    r_skid  <= w_skid_nxt;
                    r_ready <= (w_state_nxt != ST_FULL);
                end
            end

            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = NOP_DATA;
                end else begin
                    case (r_state)
                        ST_EMPTY: if (w_in_fire) begin
                            w_state_nxt = ST_ONE;
                            w_main_nxt  = i_data;
                        end
                        ST_ONE: if (w_in_fire && w_out_fire) begin
                            w_main_nxt = i_data;
                        end else if (w_in_fire) begin
                            w_state_nxt = ST_FULL;
                            w_skid_nxt  = i_data;
                        end else if (w_out_fire) begin
                            w_state_nxt = ST_EMPTY;
                        end
                        ST_FULL: if (w_out_fire) begin
                            w_state_nxt = ST_ONE;
                            w_main_nxt  = r_skid;
                        end
                        default: w_state_nxt = ST_EMPTY;
                    endcase
                end
            end

            assign o_valid = (r_state != ST_EMPTY);
            assign o_ready = r_ready;
            assign o_data  = r_main;
        end else begin : g_reg
            logic              r_valid;
            logic [DATA_W-1:0] r_main;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_valid <= 1'b0;
                    r_main  <= NOP_DATA;
                end else if (i_flush) begin
                    r_valid <= 1'b0;
                    r_main  <= NOP_DATA;
                end else if (w_in_fire) begin
                    r_valid <= 1'b1;
                    r_main  <= i_data;
                end else if (w_out_fire) begin
                    r_valid <= 1'b0;
                end
            end

            assign o_valid = r_valid;
            assign o_ready = !r_valid | i_ready;
            assign o_data  = r_main;
        end
    endgenerate

    // Flush edges are not bubbles themselves; the emptied cycles after them are.
    logic w_bubble;
    assign w_bubble = !o_valid & !i_flush;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_bubble),
        .i_clr (i_cnt_clr),
        .o_cnt (o_bubble_cnt)
    );

    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        (o_valid & !i_ready & !i_flush) |=> (o_valid & $stable(o_data)));
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: drives a skid and a non-skid stage with shared stimulus and
// checks both against a queue-based model every cycle, plus directed scenarios.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam logic [31:0] NOP_N = 32'h0BAD_0BAD;

    logic        clk = 0, reset = 1, flush = 0, valid = 0, rdy_in = 0, clr = 0;
    logic [31:0] din = 0;
    logic        rdy_s, val_s, rdy_n, val_n;
    logic [31:0] dat_s, dat_n;
    logic [3:0]  bc_s, bc_n;

    pipe_stage_skid #(.DATA_W(32), .SKID_EN(1'b1), .NOP_DATA(NOP_INSTR), .CNT_W(4)) u_s (
        .clk(clk), .reset(reset), .i_flush(flush), .i_valid(valid), .o_ready(rdy_s),
        .i_data(din), .o_valid(val_s), .i_ready(rdy_in), .o_data(dat_s),
        .o_bubble_cnt(bc_s), .i_cnt_clr(clr));

    pipe_stage_skid #(.DATA_W(32), .SKID_EN(1'b0), .NOP_DATA(NOP_N), .CNT_W(4)) u_n (
        .clk(clk), .reset(reset), .i_flush(flush), .i_valid(valid), .o_ready(rdy_n),
        .i_data(din), .o_valid(val_n), .i_ready(rdy_in), .o_data(dat_n),
        .o_bubble_cnt(bc_n), .i_cnt_clr(clr));

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a stage is a FIFO of capacity 2 (skid) or 1 (plain); the shown payload is
    // the head, or the last payload that left, or the NOP after reset/flush.
    logic [31:0] qs[$], qn[$];
    logic [31:0] hold_s, hold_n;
    int          cnt_s, cnt_n;
    bit          vs, vn, ins, inn, outs, outn;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qs.delete(); qn.delete();
            hold_s = NOP_INSTR; hold_n = NOP_N;
            cnt_s = 0; cnt_n = 0;
        end else begin
            vs   = qs.size() > 0;
            vn   = qn.size() > 0;
            ins  = valid && qs.size() < 2;
            inn  = valid && (!vn || rdy_in);
            outs = vs && rdy_in;
            outn = vn && rdy_in;
            cnt_s = clr ? 0 : (!vs && !flush && cnt_s < 15) ? cnt_s + 1 : cnt_s;
            cnt_n = clr ? 0 : (!vn && !flush && cnt_n < 15) ? cnt_n + 1 : cnt_n;
            if (flush) begin
                qs.delete(); qn.delete();
                hold_s = NOP_INSTR; hold_n = NOP_N;
            end else begin
                if (outs) hold_s = qs.pop_front();
                if (ins) qs.push_back(din);
                if (outn) hold_n = qn.pop_front();
                if (inn) qn.push_back(din);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s_valid", 32'(val_s), 32'(qs.size() > 0));
            chk("s_ready", 32'(rdy_s), 32'(qs.size() < 2));
            chk("s_data",  dat_s, qs.size() > 0 ? qs[0] : hold_s);
            chk("s_cnt",   32'(bc_s), cnt_s);
            chk("n_valid", 32'(val_n), 32'(qn.size() > 0));
            chk("n_ready", 32'(rdy_n), 32'(qn.size() == 0 || rdy_in));
            chk("n_data",  dat_n, qn.size() > 0 ? qn[0] : hold_n);
            chk("n_cnt",   32'(bc_n), cnt_n);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        valid = 0; flush = 0; clr = 0; rdy_in = 1;
        step(3);
    endtask

    initial begin
        step(2);
        reset = 0;
        chk_en = 1;
        chk("rst_valid", 32'(val_s), 0);
        chk("rst_data", dat_s, 32'h0);
        chk("rst_ready", 32'(rdy_s), 1);
        chk("rst_cnt", 32'(bc_s), 0);

        // Back-to-back into a stalled skid stage, then release.
        rdy_in = 0; valid = 1; din = 32'hA;
        step(); din = 32'hB;
        step(); din = 32'hC;
        chk("bp_ready_low", 32'(rdy_s), 0);
        step(); rdy_in = 1;
        chk("bp_out_a", dat_s, 32'hA);
        step();
        chk("bp_out_b", dat_s, 32'hB);
        step(); valid = 0;
        chk("bp_out_c", dat_s, 32'hC);
        step();
        chk("bp_drained", 32'(val_s), 0);
        drain();

        // Streaming 1..8 with counter cleared on the first edge.
        clr = 1; valid = 1; rdy_in = 1; din = 1;
        for (int k = 1; k <= 8; k++) begin
            step(); clr = 0;
            chk("str_data", dat_s, k);
            chk("str_ready", 32'(rdy_s), 1);
            if (k < 8) din = k + 1; else valid = 0;
        end
        chk("str_cnt", 32'(bc_s), 0);
        drain();

        // Flush from FULL with a same-cycle upstream payload.
        rdy_in = 0; valid = 1; din = 32'h11;
        step(); din = 32'h22;
        step(); din = 32'h33; flush = 1;
        step(); flush = 0; valid = 0;
        chk("fl_valid", 32'(val_s), 0);
        chk("fl_data", dat_s, 32'h0);
        chk("fl_ready", 32'(rdy_s), 1);
        rdy_in = 1;
        step();
        chk("fl_no_33", 32'(val_s), 0);
        drain();

        // Flush during a stall.
        rdy_in = 0; valid = 1; din = 32'h44;
        step(); valid = 0;
        step(); flush = 1;
        step(); flush = 0;
        chk("fls_valid", 32'(val_s), 0);
        drain();

        // Counter saturation and clear.
        clr = 1;
        step(); clr = 0;
        step(20);
        chk("sat_cnt", 32'(bc_s), 15);
        clr = 1;
        step(); clr = 0;
        chk("clr_cnt", 32'(bc_s), 0);

        // Asynchronous reset while FULL, between edges.
        rdy_in = 0; valid = 1; din = 32'h5;
        step(); din = 32'h6;
        step(); valid = 0;
        #1 reset = 1;
        #1;
        chk("ar_valid", 32'(val_s), 0);
        chk("ar_data", dat_s, 32'h0);
        chk("ar_ready", 32'(rdy_s), 1);
        chk("ar_cnt", 32'(bc_s), 0);
        step(); reset = 0;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            valid  = $urandom_range(0, 9) < 7;
            rdy_in = $urandom_range(0, 9) < 6;
            flush  = $urandom_range(0, 99) < 3;
            clr    = $urandom_range(0, 99) < 2;
            din    = $urandom;
            step();
        end
        drain();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
